// File: rtl/ble_rx_pkg.sv
// Shared definitions for the BLE receive path: framer states, CRC polynomial,
// whitening LFSR taps and the default advertising access address.
package ble_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC     = 3'd4
    } state_t;

    // BLE CRC-24 polynomial x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1
    localparam logic [23:0] CRC_POLY = 24'h00065B;

    // Whitening LFSR x^7 + x^4 + 1: bit 6 is the output and wraps to bit 0,
    // bit 4 takes the feedback XOR
    localparam int WHITEN_TAP_OUT = 6;
    localparam int WHITEN_TAP_FB  = 4;

    // Advertising channel access address
    localparam logic [31:0] ADV_ACCESS_ADDR = 32'h8E89BED6;

endpackage

// File: rtl/ble_crc24.sv
// Serial BLE CRC-24 register: loadable preset, one bit per enabled cycle,
// plus a zero-detect of the value the register is about to take.
module ble_crc24
    import ble_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] init,
    input  logic        en,
    input  logic        bit_in,
    output logic [23:0] crc,
    output logic        zero_nxt
);

    logic        fb;
    logic [23:0] crc_nxt;

    // Galois-form update; the CRC bits themselves fed MSB-first drive it to zero
    always_comb begin
        fb       = crc[23] ^ bit_in;
        crc_nxt  = {crc[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
        zero_nxt = (crc_nxt == 24'h000000);
    end

    // CRC register: preset on load, otherwise advance on each enabled bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 24'h000000;
        end else if (load) begin
            crc <= init;
        end else if (en) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/ble_packet_framer.sv
// BLE receive framer: correlates the access address with a Hamming-distance
// tolerance, dewhitens and deserialises header and payload bytes, checks the
// CRC-24 and reports per-packet status with registered one-cycle pulses.
module ble_packet_framer
    import ble_rx_pkg::*;
#(
    parameter int MAX_PDU_LEN = 37
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic [31:0] access_addr,
    input  logic [2:0]  aa_threshold,
    input  logic        whiten_en,
    input  logic [5:0]  channel,
    input  logic [23:0] crc_init,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        packet_start,
    output logic        packet_done,
    output logic        crc_ok,
    output logic        len_err,
    output logic [7:0]  rx_len,
    output logic        busy
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PDU_LEN);

    state_t      state;
    logic [31:0] aa_sr;
    logic [5:0]  aa_cnt;      // bits received since entering SEARCH, saturates at 32
    logic [6:0]  lfsr;
    logic [2:0]  bit_cnt;     // bit position within the current byte
    logic [7:0]  byte_sr;
    logic        hdr_second;  // next header byte completed is the length byte
    logic [7:0]  pay_left;    // payload bytes still to receive
    logic [4:0]  crc_cnt;     // received CRC bits

    logic [31:0] aa_sr_nxt;
    logic        aa_full;
    logic        aa_match;
    logic        data_bit;
    logic [7:0]  byte_nxt;
    logic        byte_done;
    logic [6:0]  lfsr_nxt;
    logic [6:0]  lfsr_seed;
    logic        crc_load;
    logic        crc_en;
    logic        crc_zero_nxt;
    logic [23:0] crc_val;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        // NOTE: blocking '=' is right for local temporaries in functions and
        // always_comb; registered state is only ever assigned with '<='.
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // Correlator window, dewhitening, byte shift and LFSR next-state
    always_comb begin
        aa_sr_nxt = {bit_in, aa_sr[31:1]};
        aa_full   = (aa_cnt >= 6'd31);
        aa_match  = aa_full &&
                    (popcount32(aa_sr_nxt ^ access_addr) <= {3'b000, aa_threshold});
        data_bit  = bit_in ^ (whiten_en & lfsr[WHITEN_TAP_OUT]);
        byte_nxt  = {data_bit, byte_sr[7:1]};
        byte_done = (bit_cnt == 3'd7);
        lfsr_nxt  = {lfsr[5:0], lfsr[WHITEN_TAP_OUT]};
        lfsr_nxt[WHITEN_TAP_FB] = lfsr[WHITEN_TAP_FB-1] ^ lfsr[WHITEN_TAP_OUT];
        lfsr_seed = {channel[0], channel[1], channel[2], channel[3],
                     channel[4], channel[5], 1'b1};
        crc_load  = enable && bit_valid && (state == ST_SEARCH) && aa_match;
        crc_en    = enable && bit_valid &&
                    ((state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_CRC));
    end

    ble_crc24 u_crc (
        .clk      (clk),
        .rst      (rst),
        .load     (crc_load),
        .init     (crc_init),
        .en       (crc_en),
        .bit_in   (data_bit),
        .crc      (crc_val),
        .zero_nxt (crc_zero_nxt)
    );

    // Framer state machine, datapath registers and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            aa_sr        <= 32'd0;
            aa_cnt       <= 6'd0;
            lfsr         <= 7'd0;
            bit_cnt      <= 3'd0;
            byte_sr      <= 8'd0;
            hdr_second   <= 1'b0;
            pay_left     <= 8'd0;
            crc_cnt      <= 5'd0;
            byte_out     <= 8'd0;
            byte_valid   <= 1'b0;
            packet_start <= 1'b0;
            packet_done  <= 1'b0;
            crc_ok       <= 1'b0;
            len_err      <= 1'b0;
            rx_len       <= 8'd0;
            busy         <= 1'b0;
        end else begin
            byte_valid   <= 1'b0;
            packet_start <= 1'b0;
            packet_done  <= 1'b0;
            len_err      <= 1'b0;

            if (!enable) begin
                // Abandon any packet; byte_out, rx_len and crc_ok keep their values
                state   <= ST_IDLE;
                aa_sr   <= 32'd0;
                aa_cnt  <= 6'd0;
                bit_cnt <= 3'd0;
                byte_sr <= 8'd0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SEARCH;
                    end

                    ST_SEARCH: begin
                        if (bit_valid) begin
                            if (aa_match) begin
                                packet_start <= 1'b1;
                                crc_ok       <= 1'b0;
                                busy         <= 1'b1;
                                state        <= ST_HEADER;
                                aa_sr        <= 32'd0;
                                aa_cnt       <= 6'd0;
                                lfsr         <= lfsr_seed;
                                bit_cnt      <= 3'd0;
                                byte_sr      <= 8'd0;
                                hdr_second   <= 1'b0;
                                crc_cnt      <= 5'd0;
                            end else begin
                                aa_sr <= aa_sr_nxt;
                                if (aa_cnt != 6'd32) begin
                                    aa_cnt <= aa_cnt + 6'd1;
                                end
                            end
                        end
                    end

                    ST_HEADER, ST_PAYLOAD: begin
                        if (bit_valid) begin
                            lfsr    <= lfsr_nxt;
                            byte_sr <= byte_nxt;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                byte_out   <= byte_nxt;
                                byte_valid <= 1'b1;
                                if (state == ST_HEADER) begin
                                    if (!hdr_second) begin
                                        hdr_second <= 1'b1;
                                    end else begin
                                        rx_len   <= byte_nxt;
                                        pay_left <= byte_nxt;
                                        if (byte_nxt > MAX_LEN) begin
                                            len_err <= 1'b1;
                                            busy    <= 1'b0;
                                            state   <= ST_SEARCH;
                                        end else if (byte_nxt == 8'd0) begin
                                            state <= ST_CRC;
                                        end else begin
                                            state <= ST_PAYLOAD;
                                        end
                                    end
                                end else begin
                                    pay_left <= pay_left - 8'd1;
                                    if (pay_left == 8'd1) begin
                                        state <= ST_CRC;
                                    end
                                end
                            end
                        end
                    end

                    ST_CRC: begin
                        if (bit_valid) begin
                            lfsr    <= lfsr_nxt;
                            crc_cnt <= crc_cnt + 5'd1;
                            if (crc_cnt == 5'd23) begin
                                crc_ok      <= crc_zero_nxt;
                                packet_done <= 1'b1;
                                busy        <= 1'b0;
                                state       <= ST_SEARCH;
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ble_packet_framer.md
# ble_packet_framer

Bit-level packet framer for the BLE receive path. It consumes the single-cycle data strobe and recovered bit produced by timing recovery and the matched filter. It searches for the 32-bit access address with a programmable bit-error tolerance, then optionally dewhitens the packet and deserialises the header and payload into bytes. Finally it checks the 24-bit CRC and reports the packet result to the downstream packet buffer.

## Interface

Parameters:
- MAX_PDU_LEN, 37: largest accepted PDU length in bytes; larger header lengths abort the packet.

Ports:
- clk  in  1  16 MHz system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  1 = framer runs; 0 = forced to IDLE.
- bit_in  in  1  recovered data bit.
- bit_valid  in  1  one-cycle strobe; bit_in is sampled only when this is high.
- access_addr  in  32  access address to search for.
- aa_threshold  in  3  maximum Hamming distance accepted for a match.
- whiten_en  in  1  1 = dewhiten header, payload and CRC.
- channel  in  6  whitening seed (channel index).
- crc_init  in  24  CRC preset.
- byte_out  out  8  last assembled byte; reset value 0.
- byte_valid  out  1  one-cycle pulse per header or payload byte; reset value 0.
- packet_start  out  1  one-cycle pulse on an access-address match; reset value 0.
- packet_done  out  1  one-cycle pulse after the last CRC bit; reset value 0.
- crc_ok  out  1  CRC result; valid from packet_done until the next packet_start; reset value 0.
- len_err  out  1  one-cycle pulse when the length exceeds MAX_PDU_LEN; reset value 0.
- rx_len  out  8  PDU length from header byte 1; reset value 0.
- busy  out  1  high in HEADER, PAYLOAD and CRC; reset value 0.

## Operation

**State machine:** IDLE, SEARCH, HEADER, PAYLOAD, CRC.
- IDLE: entered whenever enable = 0.
- IDLE → SEARCH: when enable = 1.
- SEARCH: each valid bit shifts in at bit 31 of a 32-bit register `aa_sr`, which shifts right. Bit order is LSB-first on air.
  - When popcount(`aa_sr` ^ access_addr) ≤ aa_threshold, the framer pulses packet_start and enters HEADER.
  - The comparison only begins after 32 bits have been received since entering SEARCH.
- On packet_start:
  - Whitening LFSR loads with lfsr[0] = 1 and lfsr[1..6] = channel[5..0].
  - CRC register loads crc_init.
  - Bit, byte and CRC counters clear.
  - crc_ok clears.
- **Dewhitening:** when whiten_en = 1, each data bit is XORed with lfsr[6]. The LFSR then steps as follows:
  - new[0] = old[6]
  - new[4] = old[3] ^ old[6]
  - all other positions: new[n] = old[n-1]
- **Byte assembly:** LSB-first. A byte completes on its 8th bit; byte_valid pulses on each completed byte.
- **HEADER:** 2 bytes. Header byte 1 is latched into rx_len.
  - rx_len > MAX_PDU_LEN: pulse len_err, go to SEARCH (no packet_done).
  - rx_len == 0: go to CRC.
  - otherwise: go to PAYLOAD.
- **PAYLOAD:** rx_len bytes, then go to CRC.
- **CRC computation:** covers every dewhitened header and payload bit.
  - fb = crc[23] ^ bit
  - crc = {crc[22:0], 0} ^ (fb ? 24'h00065B : 0)
- **CRC state:** the 24 received CRC bits are sent MSB-first, dewhitened, and fed through the same update.
  - After bit 24: crc_ok = (crc == 0), packet_done pulses, go to SEARCH.
- **Correlator handling after a match:** `aa_sr` is cleared on leaving SEARCH. The 32-bit refill requirement applies again on return.

## Timing

- All outputs are registered.
  - packet_start, byte_valid, len_err and packet_done each assert the cycle after the bit_valid that completes their condition.
  - byte_out, rx_len and crc_ok update in that same cycle.
- Cycles with bit_valid = 0 change no state other than enable handling.
- bit_valid back-to-back on consecutive cycles must be supported: one bit per cycle with no bubbles.
- enable low in any state: IDLE on the next clock, busy drops, no packet_done, and the partial byte is discarded. byte_out, rx_len and crc_ok hold their values.
- rst asserted at any time, including mid-packet: all state and outputs return to their reset values immediately. Operation resumes in IDLE.
- Simultaneous cases:
  - enable falling on the same cycle as a completing bit: enable wins, and no pulse is produced.
  - A match on a CRC-state bit is impossible because the correlator is idle outside SEARCH.

## Structure

- Shared package `ble_rx_pkg`:
  - state enum
  - CRC polynomial 24'h00065B
  - whitening tap positions
  - default advertising access address 32'h8E89BED6
- Sub-module `ble_crc24`: serial CRC update with load, enable and zero-detect. It is instantiated once.
- Whitening LFSR and popcount stay in the top level.

## Test plan

- AA 0x8E89BED6, threshold 0, whiten_en = 0. Send header 02 03, payload AA BB CC, and the model CRC.
  - Required: packet_start ×1; byte_valid ×5 carrying 02, 03, AA, BB, CC; rx_len = 3; packet_done with crc_ok = 1.
- Same packet with the last CRC bit flipped → packet_done with crc_ok = 0.
- AA with 2 bit errors:
  - threshold 1 → no packet_start.
  - threshold 2 → packet_start.
- Header 02 30 with MAX_PDU_LEN = 37 → len_err after the 16th header bit, SEARCH, no packet_done.
- whiten_en = 1, channel 37, stimulus whitened by the model → same bytes as scenario 1 and crc_ok = 1.
- Mid-payload events:
  - enable dropped → busy = 0 next cycle; re-enable, then the next packet decodes.
  - rst pulse → all outputs 0 asynchronously.
